// File: rtl/fb_pixel_writer.sv
// Frame-buffer pixel writer: queues ray-tracer pixels and shares a single on-chip RAM
// port with VGA scan-out on a fixed four-cycle schedule (one read slot, two write slots).
module fb_pixel_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 200
) (
  input  logic        MAIN_CLK,
  input  logic        RESET,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  input  logic [8:0]  PIX_X,
  input  logic [7:0]  PIX_Y,
  input  logic [15:0] PIX_DATA,
  input  logic [15:0] RD_ADDR,
  output logic [15:0] RD_DATA,
  output logic        RD_VALID,
  output logic [15:0] OCM_ADDR,
  output logic [15:0] OCM_DATAIN,
  output logic        OCM_WE,
  input  logic [15:0] OCM_DATAOUT,
  output logic [1:0]  SLOT,
  output logic [7:0]  DROP_CNT
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      WIDTH_C  = FB_WIDTH;
  localparam logic [31:0]      HEIGHT_C = FB_HEIGHT;
  localparam logic [15:0]      PITCH_C  = 16'(FB_WIDTH);

  localparam logic [1:0] SLOT_RD_ADDR = 2'd0;
  localparam logic [1:0] SLOT_RD_DATA = 2'd1;
  localparam logic [1:0] SLOT_WR_A    = 2'd2;
  localparam logic [1:0] SLOT_WR_B    = 2'd3;

  logic [1:0]       slot_q,     slot_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [7:0]       drop_q,     drop_d;
  logic [15:0]      rd_data_q,  rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  // Each entry is {linear RAM address, colour word}.
  logic [31:0] fifo_mem [FIFO_DEPTH];

  logic        fifo_empty;
  logic        in_range;
  logic        xfer;
  logic        push;
  logic        pop;
  logic [15:0] pix_addr;
  logic [31:0] head;

  // Pixel acceptance and range check.
  assign fifo_empty = (count_q == '0);
  assign PIX_READY  = !RESET && (count_q < DEPTH_C);
  assign xfer       = PIX_VALID && PIX_READY;
  assign in_range   = ({23'd0, PIX_X} < WIDTH_C) && ({24'd0, PIX_Y} < HEIGHT_C);
  assign push       = xfer && in_range;
  assign pix_addr   = 16'(PIX_Y) * PITCH_C + 16'(PIX_X);

  // The head is only written out from a registered entry, so a pixel pushed into an
  // empty FIFO waits for the next write slot instead of bypassing straight to the RAM.
  assign head = fifo_mem[rd_ptr_q];
  assign pop  = !RESET && slot_q[1] && !fifo_empty;

  // RAM port steering follows the slot schedule.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave it unassigned (no latch).
    OCM_ADDR   = '0;
    OCM_DATAIN = '0;
    OCM_WE     = 1'b0;
    case (slot_q)
      SLOT_RD_ADDR: OCM_ADDR = RD_ADDR;
      SLOT_RD_DATA: ;
      SLOT_WR_A, SLOT_WR_B: begin
        if (!fifo_empty) begin
          OCM_ADDR   = head[31:16];
          OCM_DATAIN = head[15:0];
          OCM_WE     = !RESET;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    slot_d     = slot_q + 2'd1;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    drop_d     = drop_q;
    if (xfer && !in_range && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
    rd_data_d  = (slot_q == SLOT_RD_DATA) ? OCM_DATAOUT : rd_data_q;
    rd_valid_d = (slot_q == SLOT_RD_DATA);
  end

  always_ff @(posedge MAIN_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      slot_q     <= SLOT_RD_ADDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // NOTE: the storage array has no reset; the count and pointers alone decide which entries are live.
  always_ff @(posedge MAIN_CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {pix_addr, PIX_DATA};
    end
  end

  assign SLOT     = slot_q;
  assign DROP_CNT = drop_q;
  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;

  a_no_overflow: assert property (@(posedge MAIN_CLK) disable iff (RESET)
    !(push && (count_q == DEPTH_C)));
  a_no_underflow: assert property (@(posedge MAIN_CLK) disable iff (RESET)
    !(pop && fifo_empty));
  a_write_slots_only: assert property (@(posedge MAIN_CLK)
    OCM_WE |-> slot_q[1]);

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: RAM model, slot/count model and a write scoreboard.
module tb_fb_pixel_writer;

  localparam int DEPTH = 8;
  localparam int FB_W  = 320;

  logic        MAIN_CLK = 1'b0;
  logic        RESET;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic [8:0]  PIX_X;
  logic [7:0]  PIX_Y;
  logic [15:0] PIX_DATA;
  logic [15:0] RD_ADDR;
  logic [15:0] RD_DATA;
  logic        RD_VALID;
  logic [15:0] OCM_ADDR;
  logic [15:0] OCM_DATAIN;
  logic        OCM_WE;
  logic [15:0] OCM_DATAOUT;
  logic [1:0]  SLOT;
  logic [7:0]  DROP_CNT;

  fb_pixel_writer #(.FIFO_DEPTH(DEPTH), .FB_WIDTH(FB_W), .FB_HEIGHT(200)) dut (
    .MAIN_CLK(MAIN_CLK), .RESET(RESET), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_DATA(PIX_DATA), .RD_ADDR(RD_ADDR),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .OCM_ADDR(OCM_ADDR), .OCM_DATAIN(OCM_DATAIN),
    .OCM_WE(OCM_WE), .OCM_DATAOUT(OCM_DATAOUT), .SLOT(SLOT), .DROP_CNT(DROP_CNT)
  );

  always #5 MAIN_CLK = ~MAIN_CLK;

  typedef struct {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [15:0] data;
    logic        ok;
    logic [15:0] addr;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // On-chip RAM model: one-cycle registered read, plus a bench-side preload port.
  logic [15:0] mem [0:65535];
  logic        tb_we = 1'b0;
  logic [15:0] tb_addr = '0;
  logic [15:0] tb_wdata = '0;

  always @(posedge MAIN_CLK) begin
    if (tb_we) mem[tb_addr] <= tb_wdata;
    else if (OCM_WE) mem[OCM_ADDR] <= OCM_DATAIN;
    OCM_DATAOUT <= mem[OCM_ADDR];
  end

  // Driver side-band: what the scoreboard should expect for the pixel being offered.
  logic        drv_ok = 1'b0;
  logic [15:0] drv_addr = '0;

  logic [31:0] sb [$];
  int          mcount = 0;
  logic [1:0]  mslot = 2'd0;
  bit          known = 1'b0;
  logic [15:0] rd_exp = '0;
  bit          rd_armed = 1'b0;
  int          wr_seen = 0;

  always @(negedge MAIN_CLK) begin : mon
    logic        exp_ready;
    logic        exp_we;
    logic [31:0] exp_w;
    int          pushed;
    exp_ready = !RESET && (mcount < DEPTH);
    exp_we    = !RESET && mslot[1] && (mcount != 0);
    pushed    = 0;
    if (known) begin
      check("slot", 32'(SLOT), 32'(mslot));
      check("pix_ready", 32'(PIX_READY), 32'(exp_ready));
      check("ocm_we", 32'(OCM_WE), 32'(exp_we));
      if (OCM_WE) begin
        wr_seen++;
        check("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          check("wr_addr", 32'(OCM_ADDR), 32'(exp_w[31:16]));
          check("wr_data", 32'(OCM_DATAIN), 32'(exp_w[15:0]));
        end
      end else if (!RESET) begin
        check("ocm_addr_idle", 32'(OCM_ADDR), (mslot == 2'd0) ? 32'(RD_ADDR) : 32'd0);
        check("ocm_din_idle", 32'(OCM_DATAIN), 32'd0);
      end
      if (mslot == 2'd2) begin
        check("rd_valid_slot2", 32'(RD_VALID), 32'd1);
        if (rd_armed) check("rd_data", 32'(RD_DATA), 32'(rd_exp));
      end else begin
        check("rd_valid_off", 32'(RD_VALID), 32'd0);
      end
    end
    if (!RESET && mslot == 2'd0) begin
      rd_exp   = mem[RD_ADDR];
      rd_armed = 1'b1;
    end
    if (RESET && mslot == 2'd1) rd_armed = 1'b0;
    if (!RESET && PIX_VALID && exp_ready && drv_ok) begin
      sb.push_back({drv_addr, PIX_DATA});
      pushed = 1;
    end
    mcount = mcount + pushed - (exp_we ? 1 : 0);
    if (RESET) begin
      mcount = 0;
      sb.delete();
    end
    mslot = RESET ? 2'd0 : mslot + 2'd1;
    known = 1'b1;
  end

  function automatic logic [15:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
    return 16'(int'(y) * FB_W + int'(x));
  endfunction

  bit full_armed = 1'b0;
  bit full_done  = 1'b0;

  task automatic tick();
    @(posedge MAIN_CLK);
    #1;
  endtask

  task automatic drive_pix(input logic [8:0] x, input logic [7:0] y, input logic [15:0] d,
                           input logic ok, input logic [15:0] a);
    PIX_VALID = 1'b1;
    PIX_X     = x;
    PIX_Y     = y;
    PIX_DATA  = d;
    drv_ok    = ok;
    drv_addr  = a;
  endtask

  // Offers one pixel and returns just after the edge that accepted it.
  task automatic push_pixel(input logic [8:0] x, input logic [7:0] y, input logic [15:0] d,
                            input logic ok, input logic [15:0] a);
    bit acc;
    acc = 1'b0;
    drive_pix(x, y, d, ok, a);
    for (int c = 0; c < 64 && !acc; c++) begin
      @(negedge MAIN_CLK);
      acc = PIX_READY;
      if (full_armed) begin
        check("ready_after_full_pop", 32'(PIX_READY), 32'd1);
        full_armed = 1'b0;
        full_done  = 1'b1;
      end
      if (!PIX_READY && OCM_WE && !full_done) full_armed = 1'b1;
      tick();
    end
    check("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && (sb.size() != 0 || mcount != 0); c++) tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    PIX_VALID = 1'b0;
    RESET     = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [10];
    int   exp_drops;
    int   w0;
    int   n;
    bit   found;

    vecs[0] = '{x: 9'd5,   y: 8'd2,   data: 16'h0F0F, ok: 1'b1, addr: 16'd645};
    vecs[1] = '{x: 9'd0,   y: 8'd0,   data: 16'h1111, ok: 1'b1, addr: 16'd0};
    vecs[2] = '{x: 9'd320, y: 8'd0,   data: 16'hDEAD, ok: 1'b0, addr: 16'd0};
    vecs[3] = '{x: 9'd319, y: 8'd199, data: 16'h2222, ok: 1'b1, addr: 16'd63999};
    vecs[4] = '{x: 9'd0,   y: 8'd200, data: 16'hBEEF, ok: 1'b0, addr: 16'd0};
    vecs[5] = '{x: 9'd10,  y: 8'd100, data: 16'h3333, ok: 1'b1, addr: 16'd32010};
    vecs[6] = '{x: 9'd511, y: 8'd255, data: 16'hF00D, ok: 1'b0, addr: 16'd0};
    vecs[7] = '{x: 9'd319, y: 8'd0,   data: 16'h4444, ok: 1'b1, addr: 16'd319};
    vecs[8] = '{x: 9'd0,   y: 8'd199, data: 16'h5555, ok: 1'b1, addr: 16'd63680};
    vecs[9] = '{x: 9'd200, y: 8'd150, data: 16'h6666, ok: 1'b1, addr: 16'd48200};

    RESET = 1'b1; PIX_VALID = 1'b0; PIX_X = '0; PIX_Y = '0; PIX_DATA = '0; RD_ADDR = '0;
    repeat (3) @(posedge MAIN_CLK);
    #1;
    RESET = 1'b0;
    @(negedge MAIN_CLK);
    check("reset_slot", 32'(SLOT), 32'd0);
    check("reset_ready", 32'(PIX_READY), 32'd1);
    check("reset_drop", 32'(DROP_CNT), 32'd0);
    check("reset_rd_data", 32'(RD_DATA), 32'd0);
    check("reset_rd_valid", 32'(RD_VALID), 32'd0);
    tick();

    // Table of single pixels: writes go to the scoreboard, drops are counted here.
    exp_drops = 0;
    for (int i = 0; i < 10; i++) begin
      push_pixel(vecs[i].x, vecs[i].y, vecs[i].data, vecs[i].ok, vecs[i].addr);
      if (!vecs[i].ok) exp_drops++;
      check("tbl_drop_cnt", 32'(DROP_CNT), 32'(exp_drops));
    end
    PIX_VALID = 1'b0;
    drain();

    // Pixel into an empty FIFO during a write slot must wait for the next write slot.
    for (int c = 0; c < 8 && mslot != 2'd2; c++) tick();
    w0 = wr_seen;
    drive_pix(9'd5, 8'd2, 16'h0F0F, 1'b1, 16'd645);
    @(negedge MAIN_CLK);
    check("single_no_same_cycle_we", 32'(OCM_WE), 32'd0);
    check("single_ready", 32'(PIX_READY), 32'd1);
    tick();
    PIX_VALID = 1'b0;
    @(negedge MAIN_CLK);
    check("single_we", 32'(OCM_WE), 32'd1);
    check("single_addr", 32'(OCM_ADDR), 32'd645);
    check("single_data", 32'(OCM_DATAIN), 32'h0F0F);
    tick();
    repeat (8) tick();
    check("single_one_write", 32'(wr_seen - w0), 32'd1);
    check("single_empty", 32'(sb.size()), 32'd0);

    // Out-of-range pixels: counted, never written, counter saturates.
    do_reset();
    check("drop_after_reset", 32'(DROP_CNT), 32'd0);
    w0 = wr_seen;
    push_pixel(9'd320, 8'd0, 16'hAAAA, 1'b0, 16'd0);
    push_pixel(9'd0, 8'd200, 16'hBBBB, 1'b0, 16'd0);
    PIX_VALID = 1'b0;
    check("drop_two", 32'(DROP_CNT), 32'd2);
    for (int i = 0; i < 300; i++) begin
      push_pixel(9'(320 + (i % 192)), 8'(i % 256), 16'(i), 1'b0, 16'd0);
    end
    PIX_VALID = 1'b0;
    check("drop_saturated", 32'(DROP_CNT), 32'd255);
    check("drop_no_writes", 32'(wr_seen - w0), 32'd0);

    // Back-to-back burst long enough to fill the FIFO and exercise back-pressure.
    full_done = 1'b0;
    for (int i = 0; i < 24; i++) begin
      push_pixel(9'(3 * i + 1), 8'(i + 1), 16'hC000 + 16'(i), 1'b1,
                 pix_addr(9'(3 * i + 1), 8'(i + 1)));
    end
    PIX_VALID = 1'b0;
    check("burst_hit_full_and_recovered", 32'(full_done), 32'd1);
    drain();

    // Scan-out read path with a held read address.
    tb_addr = 16'd100; tb_wdata = 16'hABCD; tb_we = 1'b1;
    tick();
    tb_we = 1'b0;
    RD_ADDR = 16'd100;
    repeat (4) tick();
    n = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge MAIN_CLK);
      if (RD_VALID) begin
        n++;
        check("rd_data_abcd", 32'(RD_DATA), 32'hABCD);
      end
      tick();
    end
    check("rd_pulse_count", 32'(n), 32'd4);

    // Fill to five entries and pulse reset in a write slot; nothing queued may be written.
    found = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      if (mslot == 2'd2 && mcount == 5) begin
        found = 1'b1;
      end else begin
        if (mslot == 2'd1 && mcount >= 5) PIX_VALID = 1'b0;
        else drive_pix(9'(40 + c), 8'd50, 16'h5000 + 16'(c), 1'b1, pix_addr(9'(40 + c), 8'd50));
        tick();
      end
    end
    check("reset_setup_five", 32'(found), 32'd1);
    PIX_VALID = 1'b0;
    RESET = 1'b1;
    @(negedge MAIN_CLK);
    check("reset_cycle_we", 32'(OCM_WE), 32'd0);
    check("reset_cycle_ready", 32'(PIX_READY), 32'd0);
    tick();
    RESET = 1'b0;
    w0 = wr_seen;
    @(negedge MAIN_CLK);
    check("post_reset_slot", 32'(SLOT), 32'd0);
    check("post_reset_drop", 32'(DROP_CNT), 32'd0);
    check("post_reset_ready", 32'(PIX_READY), 32'd1);
    tick();
    repeat (20) tick();
    check("post_reset_no_writes", 32'(wr_seen - w0), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
